// File: rtl/gf180mcu_clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_clkdiv_pkg
// Purpose  : Shared types and constants for the programmable clock divider.
// Revision : 1.0 - initial release
// ============================================================================
package gf180mcu_clkdiv_pkg;

  // Default width of the divide-ratio field
  localparam int DEFAULT_WIDTH = 4;

  // Largest ratio representable at the default width (used by benches)
  localparam int MAX_RATIO = (2 ** DEFAULT_WIDTH) - 1;

  // Divider phase: stopped, output-high phase, output-low phase
  typedef enum logic [1:0] {
    STOP = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gf180mcu_clkdiv_ratio_hs.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_clkdiv_ratio_hs
// Purpose  : Pending-ratio holding register and DIV_RDY handshake logic.
//            While the divider runs, an accepted ratio waits here until the
//            top commits it at a low-to-high phase boundary.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_clkdiv_ratio_hs
  import gf180mcu_clkdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_div_vld,
  input  logic             i_running,
  input  logic             i_commit,
  output logic [WIDTH-1:0] o_pnd,
  output logic             o_pv,
  output logic             o_rdy
);

  logic [WIDTH-1:0] r_pnd;
  logic             r_pv;
  logic             r_rdy;
  logic             w_xfer;
  logic             w_capture;
  logic             w_pv_nxt;

  // A commit only happens with pv set, when ready is low, so it can never
  // coincide with a capture; clearing still takes priority for safety.
  assign w_xfer    = i_div_vld & r_rdy;
  assign w_capture = w_xfer & i_running;
  assign w_pv_nxt  = i_commit ? 1'b0 : (w_capture ? 1'b1 : r_pv);

  // Hold the pending ratio; ready is registered as the inverse of next pv
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pnd <= '0;
      r_pv  <= 1'b0;
      r_rdy <= 1'b1;
    end else begin
      if (w_capture) begin
        r_pnd <= i_div;
      end
      r_pv  <= w_pv_nxt;
      r_rdy <= ~w_pv_nxt;
    end
  end

  assign o_pnd = r_pnd;
  assign o_pv  = r_pv;
  assign o_rdy = r_rdy;

endmodule
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog
// Purpose  : Programmable glitch-free clock divider, 50% duty, period
//            2*(ratio+1) source cycles, with run/stop gating. Ratio changes
//            take effect only at a low-to-high boundary.
//            Optional macro GF180MCU_CLKDIV_TICK_EN adds the TICK output.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog
  import gf180mcu_clkdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             DIV_VLD,
  output logic             DIV_RDY,
  output logic             Z
`ifdef GF180MCU_CLKDIV_TICK_EN
  ,
  output logic             TICK
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_act;
  logic [WIDTH-1:0] w_act_nxt;
  logic             r_z;
  logic             w_z_nxt;
  logic             w_commit;
  logic             w_phase_end;
  logic             w_running;
  logic             w_xfer;
  logic [WIDTH-1:0] w_pnd;
  logic             w_pv;
  logic             w_rdy;

  assign w_running   = (r_state != STOP);
  assign w_xfer      = DIV_VLD & w_rdy;
  assign w_phase_end = (r_cnt == r_act);

  gf180mcu_clkdiv_ratio_hs #(
    .WIDTH (WIDTH)
  ) u_ratio_hs (
    .clk       (CLK),
    .rst       (RST),
    .i_div     (DIV),
    .i_div_vld (DIV_VLD),
    .i_running (w_running),
    .i_commit  (w_commit),
    .o_pnd     (w_pnd),
    .o_pv      (w_pv),
    .o_rdy     (w_rdy)
  );

  // Next-state, counter, active-ratio and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_act_nxt   = r_act;
    w_z_nxt     = r_z;
    w_commit    = 1'b0;
    case (r_state)
      STOP: begin
        w_cnt_nxt = '0;
        w_z_nxt   = 1'b0;
        // Stopped: an accepted ratio is applied straight away
        if (w_xfer) begin
          w_act_nxt = DIV;
        end
        if (EN) begin
          w_state_nxt = HI;
          w_z_nxt     = 1'b1;
        end
      end
      HI: begin
        w_z_nxt = 1'b1;
        if (w_phase_end) begin
          w_state_nxt = LO;
          w_cnt_nxt   = '0;
          w_z_nxt     = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end
      LO: begin
        w_z_nxt = 1'b0;
        if (w_phase_end) begin
          w_cnt_nxt = '0;
          // The pending ratio commits even when the divider is stopping
          if (w_pv) begin
            w_commit  = 1'b1;
            w_act_nxt = w_pnd;
          end
          if (EN) begin
            w_state_nxt = HI;
            w_z_nxt     = 1'b1;
          end else begin
            w_state_nxt = STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = STOP;
        w_cnt_nxt   = '0;
        w_z_nxt     = 1'b0;
      end
    endcase
  end

  // State, counter, active ratio and the glitch-free output flop
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= STOP;
      r_cnt   <= '0;
      r_act   <= '0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_act   <= w_act_nxt;
      r_z     <= w_z_nxt;
    end
  end

  assign Z       = r_z;
  assign DIV_RDY = w_rdy;

`ifdef GF180MCU_CLKDIV_TICK_EN
  logic r_tick;

  // One-cycle pulse in the cycle Z first reads high
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= (w_state_nxt == HI) && (r_state != HI);
    end
  end

  assign TICK = r_tick;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog
// Purpose  : Self-checking bench: directed scenarios plus random stimulus,
//            compared every cycle against a phase-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog;
  import gf180mcu_clkdiv_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [3:0] DIV;
  logic       DIV_VLD;
  logic       DIV_RDY;
  logic       Z;
`ifdef GF180MCU_CLKDIV_TICK_EN
  logic       TICK;
`endif

  int n_tests;
  int n_fail;

  // Reference model: running flag, output level, cycles left in the
  // current phase, active ratio, pending ratio (-1 = none)
  int m_run, m_z, m_left, m_act, m_pend, m_rdy, m_tick;

  logic [11:0] pat;
  logic [11:0] rdyp;
  bit          found;

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .DIV     (DIV),
    .DIV_VLD (DIV_VLD),
    .DIV_RDY (DIV_RDY),
    .Z       (Z)
`ifdef GF180MCU_CLKDIV_TICK_EN
    ,
    .TICK    (TICK)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit en, input int div, input bit vld, input bit rst);
    bit xfer;
    int z_old;
    xfer  = vld && (m_rdy != 0);
    z_old = m_z;
    if (rst) begin
      m_run = 0; m_z = 0; m_left = 0; m_act = 0; m_pend = -1;
    end else if (m_run == 0) begin
      if (xfer) m_act = div;
      if (en) begin
        m_run = 1; m_z = 1; m_left = m_act;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (xfer) m_pend = div;
    end else if (m_z != 0) begin
      m_z = 0; m_left = m_act;
      if (xfer) m_pend = div;
    end else begin
      if (m_pend >= 0) begin
        m_act = m_pend; m_pend = -1;
      end
      if (xfer) m_pend = div;
      if (en) begin
        m_z = 1; m_left = m_act;
      end else begin
        m_run = 0;
      end
    end
    m_rdy  = (m_pend < 0) ? 1 : 0;
    m_tick = (m_z != 0 && z_old == 0) ? 1 : 0;
  endtask

  task automatic step(input bit en, input logic [3:0] div, input bit vld, input bit rst);
    EN = en; DIV = div; DIV_VLD = vld; RST = rst;
    @(posedge CLK);
    model_edge(en, int'(div), vld, rst);
    #1;
    check("z", 32'(Z), m_z);
    check("rdy", 32'(DIV_RDY), m_rdy);
`ifdef GF180MCU_CLKDIV_TICK_EN
    check("tick", 32'(TICK), m_tick);
`endif
  endtask

  // Safety net against a stuck run
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0;
    m_run = 0; m_z = 0; m_left = 0; m_act = 0; m_pend = -1; m_rdy = 1; m_tick = 0;
    EN = 0; DIV = 0; DIV_VLD = 0; RST = 1;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rst_z", 32'(Z), 0);
    check("rst_rdy", 32'(DIV_RDY), 1);

    // Ratio 0: divide by 2
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0); pat = {pat[10:0], Z};
    end
    check("div2_pat", 32'(pat), 32'b101010);

    // Stop, then load ratio 3 while stopped
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("stop_z", 32'(Z), 0);
    step(0, 4'd3, 1, 0);
    check("stop_load_rdy", 32'(DIV_RDY), 1);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0); pat = {pat[10:0], Z};
    end
    check("div8_pat", 32'(pat), 32'b11110000);

    // Load ratio 1 mid-HI at ratio 3
    step(1, 0, 0, 0);
    step(1, 4'd1, 1, 0);
    check("mid_hi_rdy", 32'(DIV_RDY), 0);
    pat = '0; rdyp = '0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0); pat = {pat[10:0], Z}; rdyp = {rdyp[10:0], DIV_RDY};
    end
    check("ratio_switch_pat", 32'(pat), 32'b110000110011);
    check("ratio_switch_rdy", 32'(rdyp), 32'b000000111111);

    // Move to ratio 2, then drop EN one cycle into HI
    step(1, 4'd2, 1, 0);
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_run != 0 && m_z != 0 && m_left == m_act && m_act == 2) found = 1;
      else step(1, 0, 0, 0);
    end
    check("en_drop_wait", 32'(found), 1);
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0); pat = {pat[10:0], Z};
    end
    check("en_drop_pat", 32'(pat), 32'b1100000);

    // Handshake exactly at the LO->HI boundary with nothing pending
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_run != 0 && m_z == 0 && m_left == 0 && m_pend < 0) found = 1;
      else step(1, 0, 0, 0);
    end
    check("bnd_wait", 32'(found), 1);
    step(1, 4'd5, 1, 0);
    check("bnd_rdy", 32'(DIV_RDY), 0);
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0); pat = {pat[10:0], Z};
    end
    check("bnd_pat", 32'(pat), 32'b110001111110);

    // Reset mid-HI with a ratio pending
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_z != 0 && m_left >= 2 && m_rdy != 0) found = 1;
      else step(1, 0, 0, 0);
    end
    check("rst_mid_wait", 32'(found), 1);
    step(1, 4'd7, 1, 0);
    check("rst_mid_pv", 32'(DIV_RDY), 0);
    step(1, 0, 0, 1);
    check("rst_mid_z", 32'(Z), 0);
    check("rst_mid_rdy", 32'(DIV_RDY), 1);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0); pat = {pat[10:0], Z};
    end
    check("rst_mid_pat", 32'(pat), 32'b101010);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) != 0),
           4'($urandom_range(0, MAX_RATIO)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
